// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, rounding modes and
// saturation limits used by the twiddle multiplier and its helpers.
package fft_pkg;

    localparam int DEF_DATA_W    = 17;
    localparam int DEF_DATA_FRAC = 8;
    localparam int DEF_COEF_W    = 8;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_e;

    // Largest positive value representable in a w-bit signed word.
    function automatic longint SAT_MAX(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint SAT_MIN(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/round_sat.sv
// Optional round-half-up, arithmetic right shift and clamp of a signed
// value into a narrower signed word, flagging when the clamp engaged.
module round_sat
    import fft_pkg::*;
#(
    parameter int     IN_W  = 26,
    parameter int     SHIFT = 7,
    parameter int     OUT_W = 17,
    parameter round_e MODE  = RND_HALF_UP
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] result,
    output logic                    ovf
);

    // One guard bit so the rounding addend can never wrap the sum.
    localparam int EXT_W = IN_W + 1;

    localparam logic signed [EXT_W-1:0] RND_ADD =
        (MODE == RND_HALF_UP && SHIFT > 0) ? (EXT_W'(1) <<< (SHIFT - 1)) : '0;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'(SAT_MAX(OUT_W));
    localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(SAT_MIN(OUT_W));

    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shifted;

    assign sum     = EXT_W'(value) + RND_ADD;
    assign shifted = sum >>> SHIFT;

    always_comb begin
        ovf    = 1'b0;
        result = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            result = MAX_V[OUT_W-1:0];
            ovf    = 1'b1;
        end else if (shifted < MIN_V) begin
            result = MIN_V[OUT_W-1:0];
            ovf    = 1'b1;
        end
    end

endmodule

// File: rtl/cmplx_twiddle_mult_pipe.sv
// Three-stage complex twiddle multiplier: out = in * coef (or conj(coef)),
// with rounding, saturation, unity-twiddle bypass and valid/ready flow control.
module cmplx_twiddle_mult_pipe
    import fft_pkg::*;
#(
    parameter int     DATA_W    = DEF_DATA_W,
    parameter int     DATA_FRAC = DEF_DATA_FRAC,
    parameter int     COEF_W    = DEF_COEF_W,
    parameter round_e ROUND     = RND_HALF_UP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic [COEF_W-1:0] coef_re,
    input  logic [COEF_W-1:0] coef_im,
    input  logic              coef_bypass,
    input  logic              conj,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_ovf
);

    localparam int CX_W   = COEF_W + 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;

    if (DATA_FRAC < 0 || DATA_FRAC >= DATA_W) begin : g_bad_frac
        $error("DATA_FRAC must lie in [0, DATA_W-1]");
    end

    // Handshake: a sample moves on valid & ready. The whole pipe advances
    // together on en, so in_ready falls in the very cycle the output stalls.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic                     s1_valid, s1_bypass;
    logic signed [DATA_W-1:0] s1_re, s1_im;
    logic signed [CX_W-1:0]   s1_cre, s1_cim;

    logic                     s2_valid, s2_bypass;
    logic signed [DATA_W-1:0] s2_re, s2_im;
    logic signed [PROD_W-1:0] s2_ac, s2_bd, s2_ad, s2_bc;

    logic signed [CX_W-1:0]   cim_ext;
    logic signed [SUM_W-1:0]  sum_re, sum_im;
    logic signed [DATA_W-1:0] sat_re, sat_im;
    logic                     ovf_re, ovf_im;

    // The extra coefficient bit lets conj(-1.0) become an exact +1.0.
    assign cim_ext = CX_W'($signed(coef_im));
    assign sum_re  = SUM_W'(s2_ac) - SUM_W'(s2_bd);
    assign sum_im  = SUM_W'(s2_ad) + SUM_W'(s2_bc);

    round_sat #(
        .IN_W (SUM_W),
        .SHIFT(COEF_W - 1),
        .OUT_W(DATA_W),
        .MODE (ROUND)
    ) u_sat_re (
        .value (sum_re),
        .result(sat_re),
        .ovf   (ovf_re)
    );

    round_sat #(
        .IN_W (SUM_W),
        .SHIFT(COEF_W - 1),
        .OUT_W(DATA_W),
        .MODE (ROUND)
    ) u_sat_im (
        .value (sum_im),
        .result(sat_im),
        .ovf   (ovf_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_cre    <= '0;
            s1_cim    <= '0;
            s2_valid  <= 1'b0;
            s2_bypass <= 1'b0;
            s2_re     <= '0;
            s2_im     <= '0;
            s2_ac     <= '0;
            s2_bd     <= '0;
            s2_ad     <= '0;
            s2_bc     <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_bypass <= coef_bypass;
            s1_re     <= $signed(in_re);
            s1_im     <= $signed(in_im);
            s1_cre    <= CX_W'($signed(coef_re));
            s1_cim    <= conj ? -cim_ext : cim_ext;

            s2_valid  <= s1_valid;
            s2_bypass <= s1_bypass;
            s2_re     <= s1_re;
            s2_im     <= s1_im;
            s2_ac     <= PROD_W'(s1_re) * PROD_W'(s1_cre);
            s2_bd     <= PROD_W'(s1_im) * PROD_W'(s1_cim);
            s2_ad     <= PROD_W'(s1_re) * PROD_W'(s1_cim);
            s2_bc     <= PROD_W'(s1_im) * PROD_W'(s1_cre);

            out_valid <= s2_valid;
            out_re    <= s2_bypass ? s2_re : sat_re;
            out_im    <= s2_bypass ? s2_im : sat_im;
            out_ovf   <= !s2_bypass && (ovf_re || ovf_im);
        end
    end

endmodule

// File: tb/tb_cmplx_twiddle_mult_pipe.sv
// Bench for cmplx_twiddle_mult_pipe: a rounding and a truncating instance share
// stimulus; outputs are checked against an arithmetic model of the complex product.
module tb_cmplx_twiddle_mult_pipe;
    import fft_pkg::*;

    localparam int DW = 17;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_re = '0, in_im = '0;
    logic [CW-1:0] coef_re = '0, coef_im = '0;
    logic          coef_bypass = 1'b0, conj = 1'b0;

    logic          in_ready, out_valid, out_ovf;
    logic [DW-1:0] out_re, out_im;
    logic          t_in_ready, t_out_valid, t_out_ovf;
    logic [DW-1:0] t_out_re, t_out_im;

    int n_checks = 0;
    int n_errors = 0;
    int n_out = 0;
    logic rand_done = 1'b0;

    // Each entry: {ovf, re, im} for round-half-up, then the same for truncation.
    logic [69:0] exp_q[$];

    always #5 clk = ~clk;

    cmplx_twiddle_mult_pipe #(.ROUND(RND_HALF_UP)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .coef_re(coef_re), .coef_im(coef_im),
        .coef_bypass(coef_bypass), .conj(conj), .out_valid(out_valid),
        .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf)
    );

    cmplx_twiddle_mult_pipe #(.ROUND(RND_TRUNC)) u_dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_re(in_re), .in_im(in_im), .coef_re(coef_re), .coef_im(coef_im),
        .coef_bypass(coef_bypass), .conj(conj), .out_valid(t_out_valid),
        .out_ready(out_ready), .out_re(t_out_re), .out_im(t_out_im), .out_ovf(t_out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Complex product with plain integer arithmetic; floor division by 2^(CW-1).
    function automatic logic [34:0] model(input logic [DW-1:0] ar, ai, input logic [CW-1:0] cr, ci,
                                          input logic byp, cj, rnd);
        longint a, b, c, d, re, im, hi, lo;
        logic ov;
        if (byp) return {1'b0, ar, ai};
        a = longint'($signed(ar));
        b = longint'($signed(ai));
        c = longint'($signed(cr));
        d = longint'($signed(ci));
        if (cj) d = -d;
        re = a * c - b * d;
        im = a * d + b * c;
        if (rnd) begin
            re = re + (longint'(1) <<< (CW - 2));
            im = im + (longint'(1) <<< (CW - 2));
        end
        re = re >>> (CW - 1);
        im = im >>> (CW - 1);
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        ov = 1'b0;
        if (re > hi) begin re = hi; ov = 1'b1; end
        else if (re < lo) begin re = lo; ov = 1'b1; end
        if (im > hi) begin im = hi; ov = 1'b1; end
        else if (im < lo) begin im = lo; ov = 1'b1; end
        return {ov, re[DW-1:0], im[DW-1:0]};
    endfunction

    function automatic logic [DW-1:0] rdata();
        if ($urandom_range(0, 5) == 0) return ($urandom_range(0, 1) == 1) ? 17'h10000 : 17'h0FFFF;
        return DW'($urandom);
    endfunction

    function automatic logic [CW-1:0] rcoef();
        if ($urandom_range(0, 5) == 0) return 8'h80;
        return CW'($urandom);
    endfunction

    // Scoreboard: check outputs against the head of the queue, then account for
    // this cycle's output and input transfers.
    always @(negedge clk) begin : monitor
        logic [69:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) check("unexpected_out", out_valid, 0);
                else begin
                    e = exp_q[0];
                    check("out_re", out_re, e[68:52]);
                    check("out_im", out_im, e[51:35]);
                    check("out_ovf", out_ovf, e[69]);
                end
            end
            if (t_out_valid) begin
                if (exp_q.size() == 0) check("t_unexpected_out", t_out_valid, 0);
                else begin
                    e = exp_q[0];
                    check("t_out_re", t_out_re, e[33:17]);
                    check("t_out_im", t_out_im, e[16:0]);
                    check("t_out_ovf", t_out_ovf, e[34]);
                end
            end
            check("in_ready", in_ready, !out_valid || out_ready);
            check("t_in_ready", t_in_ready, !t_out_valid || out_ready);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            if (in_valid && in_ready)
                exp_q.push_back({model(in_re, in_im, coef_re, coef_im, coef_bypass, conj, 1'b1),
                                 model(in_re, in_im, coef_re, coef_im, coef_bypass, conj, 1'b0)});
        end
    end

    task automatic push_sample(input logic [DW-1:0] ar, ai, input logic [CW-1:0] cr, ci,
                               input logic byp, cj);
        logic ok;
        in_re = ar; in_im = ai; coef_re = cr; coef_im = ci;
        coef_bypass = byp; conj = cj; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("push_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [DW-1:0] ar, ai, input logic [CW-1:0] cr, ci,
                           input logic byp, cj, input logic [DW-1:0] er, ei, input logic eo,
                           input logic [DW-1:0] tr, ti, input string name);
        int n;
        push_sample(ar, ai, cr, ci, byp, cj);
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"}, n, 3);
        check({name, "_re"}, out_re, er);
        check({name, "_im"}, out_im, ei);
        check({name, "_ovf"}, out_ovf, eo);
        check({name, "_t_re"}, t_out_re, tr);
        check({name, "_t_im"}, t_out_im, ti);
        check({name, "_t_ovf"}, t_out_ovf, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [34:0] m;
        int base;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_t_out_valid", t_out_valid, 0);
        check("rst_t_in_ready", t_in_ready, 1);

        m = model(17'h1FF00, 17'h0, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("model_scale_re", m[33:17], 17'h00080);
        m = model(17'h10000, 17'h10000, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
        check("model_sat", {m[34], m[33:17]}, {1'b1, 17'h0FFFF});
        m = model(17'h1FFFF, 17'h0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
        check("model_trunc_neg", m[33:17], 17'h1FFFF);

        run_one(17'h1FF00, 17'h0, 8'hC0, 8'h00, 0, 0, 17'h00080, 17'h0, 0, 17'h00080, 17'h0, "real_scale");
        run_one(17'h00100, 17'h0, 8'h00, 8'hC0, 0, 0, 17'h0, 17'h1FF80, 0, 17'h0, 17'h1FF80, "imag_tw");
        run_one(17'h00100, 17'h0, 8'h00, 8'hC0, 0, 1, 17'h0, 17'h00080, 0, 17'h0, 17'h00080, "imag_conj");
        run_one(17'h00100, 17'h0, 8'h00, 8'h80, 0, 1, 17'h0, 17'h00100, 0, 17'h0, 17'h00100, "conj_min");
        run_one(17'h10000, 17'h10000, 8'h80, 8'h00, 0, 0, 17'h0FFFF, 17'h0FFFF, 1, 17'h0FFFF, 17'h0FFFF, "sat");
        run_one(17'h00001, 17'h0, 8'h40, 8'h00, 0, 0, 17'h00001, 17'h0, 0, 17'h0, 17'h0, "rnd_pos");
        run_one(17'h1FFFF, 17'h0, 8'h40, 8'h00, 0, 0, 17'h0, 17'h0, 0, 17'h1FFFF, 17'h0, "rnd_neg");
        run_one(17'h0ABCD, 17'h1F000, 8'h80, 8'h55, 1, 1, 17'h0ABCD, 17'h1F000, 0, 17'h0ABCD, 17'h1F000, "bypass");

        // Backpressure: six back-to-back samples, output stalled after the first.
        base = n_out;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    push_sample(DW'(k * 1000 + 5), DW'(k * 7), 8'h5A, 8'hA5, 1'b0, k[0]);
            end
            begin
                for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 30 && (n_out - base) < 6; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("bp_count", n_out - base, 6);

        // Reset with two samples in flight.
        push_sample(17'h0ABCD, 17'h1F000, 8'h00, 8'h00, 1'b1, 1'b0);
        push_sample(17'h01234, 17'h1ABCD, 8'h00, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_t_out_valid", t_out_valid, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("stale_out", out_valid, 0);
        end

        // Randomized traffic with random backpressure.
        base = n_out;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    push_sample(rdata(), rdata(), rcoef(), rcoef(),
                                $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("rand_drain", exp_q.size(), 0);
        check("rand_count", n_out - base, 150);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
